// File: rtl/dpb_udp_slot_reader.sv
// rtl/dpb_udp_slot_reader.sv - streams one DPB slot to the UDP packet engine per write-master request, then acks.
// Optional watchdog enabled by defining PKT_TIMEOUT_EN.
module dpb_udp_slot_reader #(
    parameter int DW         = 128,
    parameter int SLOT_AW    = 4,
    parameter int WORD_AW    = 7,
    parameter int HOLD_CYC   = 100,
    parameter int EN_STRETCH = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic                        i_pclk,
    input  logic                        i_rst,
    input  logic                        i_req,
    input  logic [SLOT_AW-1:0]          i_req_slot,
    input  logic [WORD_AW-1:0]          i_req_words,
    input  logic [$clog2(DW/8)-1:0]     i_req_tail_bytes,
    input  logic [14:0]                 i_req_frame_rank,
    input  logic                        i_req_last,
    output logic                        o_done,
    output logic [SLOT_AW+WORD_AW-1:0]  o_bram_addr,
    input  logic [DW-1:0]               i_bram_rd_data,
    output logic                        o_pkt_start,
    output logic [DW-1:0]               o_pkt_data,
    output logic [15:0]                 o_pkt_len,
    output logic [14:0]                 o_pkt_frame_rank,
    output logic                        o_pkt_last_frame,
    output logic [15:0]                 o_pkt_ipv4_id,
    input  logic                        i_pkt_data_req,
    input  logic                        i_pkt_busy,
    output logic                        o_err
);

    localparam int BW = DW / 8;
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int SW = $clog2(EN_STRETCH + 1);
    localparam logic [WORD_AW-1:0] WORD_FIRST = WORD_AW'(1);
    localparam logic [WORD_AW-1:0] WORD_MAX   = {WORD_AW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SLOT_AW-1:0]   slot_q;
    logic [WORD_AW-1:0]   word_q;
    logic [HW-1:0]        hold_cnt;
    logic [SW-1:0]        stretch_cnt;
    logic                 data_req_q;
    logic                 req_last_q;
    logic                 accept;
    logic                 data_req_edge;
    logic                 hold_met;
    logic                 timeout_hit;
    logic [31:0]          len_full;
    logic [15:0]          len_sat;

    assign o_done        = (state == S_DONE);
    assign accept        = (state == S_IDLE) && i_req && !o_done;
    assign data_req_edge = i_pkt_data_req && !data_req_q;
    assign hold_met      = (hold_cnt == HW'(HOLD_CYC));
    assign o_bram_addr   = {slot_q, word_q};
    assign o_pkt_data    = i_bram_rd_data;
    assign o_pkt_start   = (stretch_cnt != '0);

    // Wide intermediate so oversized geometries clamp instead of wrapping.
    assign len_full = 32'(i_req_words) * 32'(BW) + 32'(i_req_tail_bytes);
    assign len_sat  = (len_full > 32'h0000_FFFF) ? 16'hFFFF : len_full[15:0];

`ifdef PKT_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT + 1);
    logic [TOW-1:0] wd_cnt;

    assign timeout_hit = (state == S_STREAM) && (wd_cnt == TOW'(TIMEOUT)) && i_pkt_busy;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            wd_cnt <= '0;
            o_err  <= 1'b0;
        end else begin
            if (accept) begin
                wd_cnt <= TOW'(1);
            end else if (state == S_STREAM && wd_cnt != TOW'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + TOW'(1);
            end
            if (timeout_hit) begin
                o_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_STREAM;
            S_STREAM: if (timeout_hit || (hold_met && !i_pkt_busy)) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            slot_q           <= '0;
            word_q           <= WORD_FIRST;
            hold_cnt         <= '0;
            stretch_cnt      <= '0;
            data_req_q       <= 1'b0;
            req_last_q       <= 1'b0;
            o_pkt_len        <= '0;
            o_pkt_frame_rank <= '0;
            o_pkt_last_frame <= 1'b0;
            o_pkt_ipv4_id    <= '0;
        end else begin
            data_req_q <= i_pkt_data_req;
            req_last_q <= i_req_last;
            if (stretch_cnt != '0) begin
                stretch_cnt <= stretch_cnt - SW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        slot_q           <= i_req_slot;
                        word_q           <= WORD_FIRST;
                        o_pkt_frame_rank <= i_req_frame_rank;
                        o_pkt_last_frame <= i_req_last;
                        o_pkt_len        <= len_sat;
                        hold_cnt         <= HW'(1);
                        stretch_cnt      <= SW'(EN_STRETCH);
                    end
                end
                S_STREAM: begin
                    // Word pointer clamps at the slot's last word so it never spills into the next slot.
                    if (data_req_edge && word_q != WORD_MAX) begin
                        word_q <= word_q + WORD_AW'(1);
                    end
                    if (i_req_last && !req_last_q) begin
                        o_pkt_last_frame <= 1'b1;
                    end
                    if (!hold_met) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_DONE: begin
                    o_pkt_ipv4_id    <= o_pkt_ipv4_id + 16'd1;
                    o_pkt_last_frame <= 1'b0;
                    word_q           <= WORD_FIRST;
                end
                default: ;
            endcase
        end
    end

endmodule
